frame_deserializer: RTL
=======================

Name: frame_deserializer

Overview:
- Parametrised serial-to-parallel receiver for the decimator serial output link (serial data plus frame-sync pulse).
- Generalises the fixed 22-bit deserializer:
  - configurable word width and bit order;
  - multiple channels packed back-to-back in one frame;
  - one-entry valid/ready output buffer with overrun reporting;
  - sync-error detection with a saturating error counter.
- Sits between the decimator serial output and downstream parallel consumers (capture logic, test benches).

Parameters:
- DATA_W, 22, bits per channel word.
- NUM_CH, 1, channel words per frame, transmitted consecutively with no gaps.
- MSB_FIRST, 1, 1: first received bit lands in data_o[DATA_W-1]; 0: first received bit lands in data_o[0].
- ERR_CNT_W, 8, width of the saturating sync-error counter.

Ports:
- clk  in  1  single system clock; all logic is rising-edge.
- rst_b  in  1  reset, asynchronous assert, active-low.
- serial_i  in  1  serial data; sampled every clk rising edge.
- frame_sync_i  in  1  one-cycle pulse, coincident with bit 0 of channel 0.
- data_o  out  DATA_W  received word (raw two's complement).
- ch_o  out  CH_W  channel index of data_o; CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1.
- valid_o  out  1  data_o/ch_o hold a word not yet accepted.
- ready_i  in  1  consumer accepts the word on any edge where valid_o && ready_i.
- overrun_o  out  1  one-cycle pulse: an unaccepted word was overwritten.
- sync_err_o  out  1  one-cycle pulse: frame_sync_i seen mid-frame.
- err_cnt_o  out  ERR_CNT_W  saturating count of sync errors.
- busy_o  out  1  FSM in SHIFT state.

Behaviour:
- Reset (rst_b=0, asynchronous): FSM=IDLE; shift register, bit_cnt, ch_cnt, data_o, ch_o, err_cnt_o = 0; valid_o, overrun_o, sync_err_o, busy_o = 0.
- FSM IDLE:
  - serial_i ignored unless frame_sync_i=1.
  - On frame_sync_i=1: sample serial_i as bit 0, bit_cnt=1, ch_cnt=0, go to SHIFT.
- FSM SHIFT:
  - Each cycle: sample serial_i into the shift register, bit_cnt++.
  - On the cycle sampling bit DATA_W-1: word complete; load the output buffer (data_o, ch_o=ch_cnt); bit_cnt=0.
  - If ch_cnt==NUM_CH-1: go to IDLE. Otherwise ch_cnt++ and stay in SHIFT; the next channel's bit 0 is sampled on the following cycle with no sync.
- Latency: sync sampled at edge T gives valid_o=1 from edge T+DATA_W for channel 0; channel k from edge T+(k+1)*DATA_W.
- Sync error (frame_sync_i=1 while in SHIFT, including on the last bit of a word):
  - Discard the partial frame; no output for the interrupted word.
  - sync_err_o pulses for one cycle, starting the next edge.
  - err_cnt_o increments, saturating at 2^ERR_CNT_W-1.
  - Restart: the current serial_i is bit 0 of channel 0 and the FSM stays in SHIFT.
  - Words already completed in the aborted frame remain valid.
- Output buffer:
  - Accept (valid_o && ready_i) with no new word: valid_o -> 0 next cycle.
  - New word with buffer empty, or with simultaneous accept: load the word, valid_o stays/becomes 1, no overrun.
  - New word with valid_o=1 && ready_i=0: overwrite with the new word, valid_o stays 1, overrun_o pulses for one cycle.
- Tie ready_i=1 for the legacy one-cycle valid pulse per word.
- data_o and ch_o hold their last loaded value after acceptance; they are don't-care for consumers while valid_o=0.
- busy_o=1 exactly while in SHIFT.
- Reset asserted mid-frame aborts the frame immediately. The buffer is cleared and is not counted as an error.

Test Plan:
1. Single word, DATA_W=22, NUM_CH=1, MSB_FIRST=1, ready_i=1. Send 22'h2AAAAA with sync at edge T. Expect: valid_o high only at T+22, data_o=22'h2AAAAA, ch_o=0, busy_o high T+1..T+22.
2. Bit order. Send -1000 (22'h3FFC18).
   - MSB_FIRST=1: data_o signed = -1000.
   - MSB_FIRST=0, sending LSB first: data_o signed = -1000.
   - MSB_FIRST=0, fed the MSB-first stream: data_o = bit-reversed 22'h3FFC18.
3. NUM_CH=4 frame carrying 1, 2, 3, -4. Expect valid pulses at T+22/44/66/88 with ch_o=0/1/2/3 and matching data. FSM returns to IDLE after T+88.
4. Sync error: second sync 10 bits into channel 0. Expect: no word output for the partial, sync_err_o one-cycle pulse, err_cnt_o=1. A full word sent after the second sync decodes correctly 22 cycles later.
5. Backpressure: ready_i=0, two words, values 5 then 7. Expect:
   - overrun_o pulses at the second completion;
   - data_o=7 and valid_o remains 1;
   - raising ready_i for one cycle drops valid_o the next cycle.
   - Simultaneous accept plus completion: no overrun.
6. Reset and saturation:
   - rst_b low at bit 11: all outputs 0; a following clean frame decodes correctly.
   - ERR_CNT_W=2 with 5 sync errors: err_cnt_o=3.

Source files
------------

// File: rtl/frame_deserializer.sv
// frame_deserializer
//   Serial-to-parallel receiver for the decimator output link. A one-cycle
//   frame_sync_i pulse marks bit 0 of channel 0. NUM_CH words of DATA_W bits
//   each follow back-to-back. Every completed word is loaded into a one-entry
//   valid/ready output buffer.
//
// Ports
//   clk          rising-edge system clock
//   rst_b        asynchronous active-low reset
//   serial_i     serial data, sampled on every clk edge
//   frame_sync_i frame-start pulse, coincident with bit 0 of channel 0
//   data_o       received word (raw two's complement)
//   ch_o         channel index of data_o
//   valid_o      data_o/ch_o hold a word that has not been accepted yet
//   ready_i      consumer accepts the word on an edge where valid_o && ready_i
//   overrun_o    one-cycle pulse: an unaccepted word was overwritten
//   sync_err_o   one-cycle pulse: frame_sync_i arrived mid-frame
//   err_cnt_o    saturating count of sync errors
//   busy_o       high while a frame is being shifted in
//
// DATA_W must be at least 2.
module frame_deserializer #(
    parameter int DATA_W    = 22,
    parameter int NUM_CH    = 1,
    parameter bit MSB_FIRST = 1'b1,
    parameter int ERR_CNT_W = 8,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 serial_i,
    input  logic                 frame_sync_i,
    output logic [DATA_W-1:0]    data_o,
    output logic [CH_W-1:0]      ch_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 overrun_o,
    output logic                 sync_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 busy_o
);

    localparam int BC_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t                 r_state, w_state_nxt;
    logic [DATA_W-1:0]      r_shift, w_shift_in;
    logic [BC_W-1:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [CH_W-1:0]        r_ch_cnt, w_ch_cnt_nxt;
    logic                   w_sample, w_done, w_err;

    // MSB-first shifts left so the first bit ends in the MSB; LSB-first shifts
    // right so the first bit ends in bit 0.
    always_comb begin
        if (MSB_FIRST) w_shift_in = {r_shift[DATA_W-2:0], serial_i};
        else           w_shift_in = {serial_i, r_shift[DATA_W-1:1]};
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sample      = 1'b0;
        w_done        = 1'b0;
        w_err         = 1'b0;
        w_bit_cnt_nxt = r_bit_cnt;
        w_ch_cnt_nxt  = r_ch_cnt;
        case (r_state)
            S_IDLE: begin
                if (frame_sync_i) begin
                    w_sample      = 1'b1;
                    w_bit_cnt_nxt = BC_W'(1);
                    w_ch_cnt_nxt  = '0;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_sample = 1'b1;
                if (frame_sync_i) begin
                    // Mid-frame sync wins even on a word's last bit: drop the
                    // partial word and restart with this bit as bit 0.
                    w_err         = 1'b1;
                    w_bit_cnt_nxt = BC_W'(1);
                    w_ch_cnt_nxt  = '0;
                end else if (r_bit_cnt == LAST_BIT) begin
                    w_done        = 1'b1;
                    w_bit_cnt_nxt = '0;
                    if (r_ch_cnt == LAST_CH) begin
                        w_ch_cnt_nxt = '0;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_ch_cnt_nxt = r_ch_cnt + CH_W'(1);
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_ch_cnt  <= '0;
        end else begin
            if (w_sample) r_shift <= w_shift_in;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_ch_cnt  <= w_ch_cnt_nxt;
        end
    end

    // Output buffer: a completed word always lands; it only counts as an
    // overrun if the previous word is still held and not being accepted now.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_o    <= '0;
            ch_o      <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else if (w_done) begin
            data_o    <= w_shift_in;
            ch_o      <= r_ch_cnt;
            valid_o   <= 1'b1;
            overrun_o <= valid_o & ~ready_i;
        end else begin
            overrun_o <= 1'b0;
            if (valid_o && ready_i) valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_err_o <= 1'b0;
            err_cnt_o  <= '0;
        end else begin
            sync_err_o <= w_err;
            if (w_err && (err_cnt_o != {ERR_CNT_W{1'b1}}))
                err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
    end

    assign busy_o = (r_state == S_SHIFT);

endmodule
